alu_ctrl_pipe: RTL and testbench

//  Registered ALU-control stage for the MIPS32 core, sitting at the ID->EX boundary.

---
 rtl/alu_ctrl_pkg.sv | 84 ++++++++
 rtl/alu_ctrl_dec.sv | 88 ++++++++
 rtl/alu_ctrl_pipe.sv | 102 ++++++++++
 tb/tb_alu_ctrl_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: ALU select codes, MIPS opcode/funct constants,
// operation classes and the HI/LO classification helpers.
package alu_ctrl_pkg;

  localparam int ALU_W = 5;

  localparam logic [ALU_W-1:0] ALU_ADD   = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'd1;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'd2;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'd3;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'd4;
  localparam logic [ALU_W-1:0] ALU_NOR   = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'd8;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'd9;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'd10;
  localparam logic [ALU_W-1:0] ALU_NEQ   = 5'd11;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'd12;
  localparam logic [ALU_W-1:0] ALU_MULT  = 5'd16;
  localparam logic [ALU_W-1:0] ALU_MULTU = 5'd17;
  localparam logic [ALU_W-1:0] ALU_DIV   = 5'd18;
  localparam logic [ALU_W-1:0] ALU_DIVU  = 5'd19;
  localparam logic [ALU_W-1:0] ALU_MFHI  = 5'd20;
  localparam logic [ALU_W-1:0] ALU_MFLO  = 5'd21;
  localparam logic [ALU_W-1:0] ALU_MTHI  = 5'd22;
  localparam logic [ALU_W-1:0] ALU_MTLO  = 5'd23;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_HILO_RD = 2'd2,
    CLS_HILO_WR = 2'd3
  } op_cls_e;

  function automatic logic is_muldiv(input logic [ALU_W-1:0] sel);
    return (sel >= ALU_MULT) && (sel <= ALU_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [ALU_W-1:0] sel);
    return (sel >= ALU_MFHI) && (sel <= ALU_MTLO);
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Pure combinational MIPS32 opcode/funct decode into ALU select, side flags,
// illegal flag and operation class.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter bit HAS_MULDIV = 1'b1
) (
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alusel,
  output logic             ovf_en,
  output logic             var_shift,
  output logic             zext_imm,
  output logic             illegal,
  output op_cls_e          cls
);

  logic             md_hit;
  logic [ALU_W-1:0] md_code;

  always_comb begin
    alusel    = ALU_ADD;
    ovf_en    = 1'b0;
    var_shift = 1'b0;
    zext_imm  = 1'b0;
    illegal   = 1'b0;
    md_hit    = 1'b0;
    md_code   = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      unique case (funct)
        FN_ADD:  begin alusel = ALU_ADD; ovf_en = 1'b1; end
        FN_ADDU: alusel = ALU_ADD;
        FN_SUB:  begin alusel = ALU_SUB; ovf_en = 1'b1; end
        FN_SUBU: alusel = ALU_SUB;
        FN_AND:  alusel = ALU_AND;
        FN_OR:   alusel = ALU_OR;
        FN_XOR:  alusel = ALU_XOR;
        FN_NOR:  alusel = ALU_NOR;
        FN_SLT:  alusel = ALU_SLT;
        FN_SLTU: alusel = ALU_SLTU;
        FN_SLL:  alusel = ALU_SLL;
        FN_SLLV: begin alusel = ALU_SLL; var_shift = 1'b1; end
        FN_SRL:  alusel = ALU_SRL;
        FN_SRLV: begin alusel = ALU_SRL; var_shift = 1'b1; end
        FN_SRA:  alusel = ALU_SRA;
        FN_SRAV: begin alusel = ALU_SRA; var_shift = 1'b1; end
        FN_JR:   alusel = ALU_ADD;
        // funct[1:0] orders MULT/MULTU/DIV/DIVU; HI/LO moves have funct[1:0] swapped vs code order
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
          md_hit  = 1'b1;
          md_code = ALU_MULT | {3'b000, funct[1:0]};
        end
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: begin
          md_hit  = 1'b1;
          md_code = ALU_MFHI | {3'b000, funct[0], funct[1]};
        end
        default: illegal = 1'b1;
      endcase
      if (md_hit) begin
        if (HAS_MULDIV) alusel = md_code;
        else            illegal = 1'b1;
      end
    end else begin
      unique case (opcode)
        OP_ADDI:        begin alusel = ALU_ADD; ovf_en = 1'b1; end
        OP_ADDIU:       alusel = ALU_ADD;
        OP_ANDI:        begin alusel = ALU_AND; zext_imm = 1'b1; end
        OP_ORI:         begin alusel = ALU_OR;  zext_imm = 1'b1; end
        OP_XORI:        begin alusel = ALU_XOR; zext_imm = 1'b1; end
        OP_LUI:         alusel = ALU_LUI;
        OP_LW, OP_SW:   alusel = ALU_ADD;
        OP_BEQ:         alusel = ALU_SUB;
        OP_BNE:         alusel = ALU_NEQ;
        OP_SLTI:        alusel = ALU_SLT;
        OP_SLTIU:       alusel = ALU_SLTU;
        default:        illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    cls = CLS_ALU;
    if (is_muldiv(alusel))                             cls = CLS_MULDIV;
    else if (alusel == ALU_MFHI || alusel == ALU_MFLO) cls = CLS_HILO_RD;
    else if (is_hilo(alusel))                          cls = CLS_HILO_WR;
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control stage at the ID->EX boundary with valid/ready handshake,
// flush and a HI/LO interlock tracking MULT/DIV latency.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ALUSEL_W   = 5,
  parameter bit HAS_MULDIV = 1'b1,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALUSEL_W-1:0] out_alusel,
  output logic                out_ovf_en,
  output logic                out_var_shift,
  output logic                out_zext_imm,
  output logic                out_illegal,
  output logic                md_busy
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

  logic [ALU_W-1:0] dec_alusel;
  logic             dec_ovf_en;
  logic             dec_var_shift;
  logic             dec_zext_imm;
  logic             dec_illegal;
  op_cls_e          dec_cls;

  logic [ALU_W-1:0] alu_q;
  op_cls_e          cls_q;
  logic [5:0]       cnt_q;
  logic             hz;
  logic             accept;
  logic             out_fire;

  alu_ctrl_dec #(.HAS_MULDIV(HAS_MULDIV)) u_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alusel    (dec_alusel),
    .ovf_en    (dec_ovf_en),
    .var_shift (dec_var_shift),
    .zext_imm  (dec_zext_imm),
    .illegal   (dec_illegal),
    .cls       (dec_cls)
  );

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and the output payload is frozen while out_valid & !out_ready.
  assign md_busy  = (cnt_q != 6'd0);
  assign hz       = (dec_cls != CLS_ALU) &&
                    (md_busy || (out_valid && (cls_q == CLS_MULDIV || cls_q == CLS_HILO_WR)));
  assign in_ready = !flush && !hz && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !flush;

  assign out_alusel = ALUSEL_W'(alu_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_q         <= ALU_ADD;
      cls_q         <= CLS_ALU;
      out_ovf_en    <= 1'b0;
      out_var_shift <= 1'b0;
      out_zext_imm  <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      alu_q         <= dec_alusel;
      cls_q         <= dec_cls;
      out_ovf_en    <= dec_ovf_en;
      out_var_shift <= dec_var_shift;
      out_zext_imm  <= dec_zext_imm;
      out_illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flush never clears the count: an already issued MULT/DIV keeps running in EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 6'd0;
    end else if (out_fire && cls_q == CLS_MULDIV) begin
      cnt_q <= (alu_q == ALU_DIV || alu_q == ALU_DIVU) ? DIV_LOAD : MUL_LOAD;
    end else if (cnt_q != 6'd0) begin
      cnt_q <= cnt_q - 6'd1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: reference decode model feeding an
// expected queue, plus directed handshake, interlock, flush and reset scenarios.
module tb_alu_ctrl_pipe;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_alusel;
  logic       out_ovf_en;
  logic       out_var_shift;
  logic       out_zext_imm;
  logic       out_illegal;
  logic       md_busy;

  logic       nomd_in_ready;
  logic       nomd_out_valid;
  logic [4:0] nomd_alusel;
  logic       nomd_ovf_en;
  logic       nomd_var_shift;
  logic       nomd_zext_imm;
  logic       nomd_illegal;
  logic       nomd_busy;

  logic [8:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  int         busy_cycles;

  alu_ctrl_pipe #(.ALUSEL_W(5), .HAS_MULDIV(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alusel(out_alusel),
    .out_ovf_en(out_ovf_en), .out_var_shift(out_var_shift), .out_zext_imm(out_zext_imm),
    .out_illegal(out_illegal), .md_busy(md_busy)
  );

  alu_ctrl_pipe #(.ALUSEL_W(5), .HAS_MULDIV(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_nomd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nomd_in_ready),
    .opcode(opcode), .funct(funct), .flush(flush),
    .out_valid(nomd_out_valid), .out_ready(1'b1), .out_alusel(nomd_alusel),
    .out_ovf_en(nomd_ovf_en), .out_var_shift(nomd_var_shift), .out_zext_imm(nomd_zext_imm),
    .out_illegal(nomd_illegal), .md_busy(nomd_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference decode: {alusel[4:0], ovf_en, var_shift, zext_imm, illegal}
  function automatic logic [8:0] ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                            input bit has_md);
    logic [4:0] a;
    logic ov, vs, zx, il;
    a = 5'd0; ov = 1'b0; vs = 1'b0; zx = 1'b0; il = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin a = 5'd0; ov = 1'b1; end
        6'h21: a = 5'd0;
        6'h22: begin a = 5'd1; ov = 1'b1; end
        6'h23: a = 5'd1;
        6'h24: a = 5'd2;
        6'h25: a = 5'd3;
        6'h26: a = 5'd4;
        6'h27: a = 5'd5;
        6'h2A: a = 5'd6;
        6'h2B: a = 5'd7;
        6'h00: a = 5'd8;
        6'h04: begin a = 5'd8; vs = 1'b1; end
        6'h02: a = 5'd9;
        6'h06: begin a = 5'd9; vs = 1'b1; end
        6'h03: a = 5'd10;
        6'h07: begin a = 5'd10; vs = 1'b1; end
        6'h08: a = 5'd0;
        6'h18: a = 5'd16;
        6'h19: a = 5'd17;
        6'h1A: a = 5'd18;
        6'h1B: a = 5'd19;
        6'h10: a = 5'd20;
        6'h12: a = 5'd21;
        6'h11: a = 5'd22;
        6'h13: a = 5'd23;
        default: il = 1'b1;
      endcase
      if (a >= 5'd16 && !has_md) begin a = 5'd0; il = 1'b1; end
    end else begin
      case (op)
        6'h08: begin a = 5'd0; ov = 1'b1; end
        6'h09: a = 5'd0;
        6'h0C: begin a = 5'd2; zx = 1'b1; end
        6'h0D: begin a = 5'd3; zx = 1'b1; end
        6'h0E: begin a = 5'd4; zx = 1'b1; end
        6'h0F: a = 5'd12;
        6'h23: a = 5'd0;
        6'h2B: a = 5'd0;
        6'h04: a = 5'd1;
        6'h05: a = 5'd11;
        6'h0A: a = 5'd6;
        6'h0B: a = 5'd7;
        default: il = 1'b1;
      endcase
    end
    return {a, ov, vs, zx, il};
  endfunction

  // one cycle: entered #1 after a rising edge with inputs already driven
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (md_busy) busy_cycles++;
    if (flush) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
      else check_val("decode", {out_alusel, out_ovf_en, out_var_shift, out_zext_imm, out_illegal},
                     exp_q.pop_front());
    end
    if (acc) exp_q.push_back(ref_decode(opcode, funct, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [5:0] fn);
    bit acc;
    int n;
    opcode = op; funct = fn; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle_until_free();
    bit acc;
    int g;
    in_valid = 1'b0; g = 0;
    while ((md_busy || out_valid) && g < 200) begin
      tick(acc);
      g++;
    end
    check_val("drain", {31'd0, md_busy | out_valid}, 32'd0);
  endtask

  logic [11:0] sweep_tab[$] = '{
    12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
    12'h02A, 12'h02B, 12'h000, 12'h004, 12'h002, 12'h006, 12'h003, 12'h007,
    12'h008, 12'h001, 12'h03F,
    12'h200, 12'h240, 12'h300, 12'h340, 12'h380, 12'h3C0, 12'h8C0, 12'hAC0,
    12'h100, 12'h140, 12'h280, 12'h2C0, 12'hFC0, 12'h080
  };
  logic [5:0] md_tab[$] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h12};

  initial begin
    bit acc;
    int stall;
    int g;
    n_checks = 0; n_fail = 0; busy_cycles = 0;
    rst_n = 1'b0; in_valid = 1'b0; opcode = 6'h00; funct = 6'h00;
    flush = 1'b0; out_ready = 1'b1;

    // reset state
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check_val("rst_alusel", {27'd0, out_alusel}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // first decode after release: SLTU
    send(6'h00, 6'h2B);
    check_val("sltu_valid", {31'd0, out_valid}, 32'd1);
    check_val("sltu_alusel", {27'd0, out_alusel}, 32'd7);

    // muldiv disabled build flags MULT and MFHI as illegal
    send(6'h00, 6'h18);
    check_val("nomd_mult_ill", {31'd0, nomd_illegal}, 32'd1);
    check_val("nomd_mult_sel", {27'd0, nomd_alusel}, 32'd0);
    send(6'h00, 6'h10);
    check_val("nomd_mfhi_ill", {31'd0, nomd_illegal}, 32'd1);
    idle_until_free();

    // decode sweep, back to back
    for (int i = 0; i < sweep_tab.size(); i++) begin
      logic [11:0] e;
      e = sweep_tab[i];
      send(e[11:6], e[5:0]);
    end
    check_val("op3f_ill", {31'd0, out_illegal}, 32'd1);
    for (int i = 0; i < md_tab.size(); i++) send(6'h00, md_tab[i]);
    idle_until_free();

    // backpressure: output frozen, input blocked
    out_ready = 1'b0;
    send(6'h00, 6'h24);
    opcode = 6'h00; funct = 6'h25; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_alusel", {27'd0, out_alusel}, 32'd2);
      tick(acc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = 6'h00;
      funct = 6'h25 + 6'(i);
      tick(acc);
      check_val("thru_accept", {31'd0, acc}, 32'd1);
    end
    idle_until_free();

    // DIV then MFLO: stalled for the whole divide latency
    send(6'h00, 6'h1A);
    tick(acc);
    check_val("div_busy", {31'd0, md_busy}, 32'd1);
    opcode = 6'h00; funct = 6'h12; in_valid = 1'b1;
    stall = 0; acc = 1'b0;
    while (!acc && stall < 100) begin
      tick(acc);
      if (!acc) stall++;
    end
    in_valid = 1'b0;
    check_val("div_stall", stall, DIV_LAT);
    check_val("mflo_sel", {27'd0, out_alusel}, 32'd21);
    check_val("mflo_busy", {31'd0, md_busy}, 32'd0);
    idle_until_free();

    // MULT consumed, flush later: counter keeps running full latency
    send(6'h00, 6'h18);
    tick(acc);
    busy_cycles = 0;
    opcode = 6'h00; funct = 6'h20; in_valid = 1'b1; out_ready = 1'b0;
    tick(acc);
    in_valid = 1'b0; flush = 1'b1;
    tick(acc);
    flush = 1'b0; out_ready = 1'b1;
    check_val("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_busy", {31'd0, md_busy}, 32'd1);
    g = 0;
    while (md_busy && g < 100) begin
      tick(acc);
      g++;
    end
    check_val("mul_busy_len", busy_cycles, MUL_LAT);

    // flush with incoming op and a held MULTU: all dropped, no counter load
    send(6'h00, 6'h19);
    flush = 1'b1; in_valid = 1'b1; opcode = 6'h00; funct = 6'h22; out_ready = 1'b1;
    #1;
    check_val("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush2_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush2_busy", {31'd0, md_busy}, 32'd0);
    tick(acc);
    check_val("flush2_busy_b", {31'd0, md_busy}, 32'd0);

    // asynchronous reset mid-operation
    send(6'h00, 6'h18);
    tick(acc);
    opcode = 6'h00; funct = 6'h20; in_valid = 1'b1; out_ready = 1'b0;
    tick(acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_val("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("arst_md_busy", {31'd0, md_busy}, 32'd0);
    check_val("arst_ovf", {31'd0, out_ovf_en}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_val("arst_in_ready", {31'd0, in_ready}, 32'd1);
    send(6'h0F, 6'h00);
    idle_until_free();

    check_val("sb_leftover", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
